oled_hex_msg_feeder: RTL and testbench
======================================

OLED_HEX_MSG_FEEDER -- requirements
Module: oled_hex_msg_feeder

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; all other ports are listed below.
REQ-002 Parameters SHALL be:
- FIFO_DEPTH, default 4: request queue entries, power of two.
- DONE_TIMEOUT, default 24'hFFFFFF: cycles to wait for disp_done.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  queue can accept
- req_pos  in  8  {x[3:0], y[3:0]} header byte
- req_len  in  2  data bytes minus 1 (1..4 bytes)
- req_value  in  32  hex payload, right-aligned
- msg_done  out  1  one-cycle pulse, message displayed
- err_timeout  out  1  sticky, disp_done never arrived
- err_clr  in  1  clears err_timeout
- busy  out  1  queue non-empty or FSM not IDLE
- disp_rdy  in  1  downstream display stage idle
- disp_wen  out  1  downstream write strobe
- disp_din  out  8  downstream byte
- disp_done  in  1  downstream completion pulse

Function
REQ-004 A request SHALL be accepted on any cycle with req_valid & req_ready; req_ready SHALL be the combinational inverse of queue-full.
REQ-005 The queue SHALL be FIFO ordered; push and pop in the same cycle SHALL both take effect, including when the queue is full, but req_ready stays 0 while full.
REQ-006 The FSM SHALL have the states IDLE, WAIT_RDY, SEND_HDR, SEND_DATA and WAIT_DONE.
REQ-007 In IDLE with the queue non-empty, the FSM SHALL pop one entry into message registers and go to WAIT_RDY the next cycle.
REQ-008 In WAIT_RDY the FSM SHALL go to SEND_HDR on the first cycle disp_rdy=1; otherwise it holds.
REQ-009 SEND_HDR SHALL last exactly 1 cycle with disp_wen=1 and disp_din=pos; it then goes to SEND_DATA.
REQ-010 SEND_DATA SHALL last exactly len+1 cycles with disp_wen=1 throughout; byte k (k=0..len) SHALL be value[8*(len-k)+7 -: 8], most significant first.
REQ-011 disp_wen SHALL be continuous from the header through the last data byte, with no gap, and SHALL drop the cycle after the last byte; disp_wen and disp_din are driven from registered state only.
REQ-012 disp_din SHALL be 8'h00 whenever disp_wen=0.
REQ-013 WAIT_DONE:
- disp_done=1 -> pulse msg_done for 1 cycle, go to IDLE.
- Timeout counter reaches DONE_TIMEOUT -> set err_timeout, go to IDLE, no msg_done.
REQ-014 The timeout counter SHALL clear on entry to WAIT_DONE and count in WAIT_DONE only; disp_done in the same cycle the count reaches DONE_TIMEOUT SHALL count as success.
REQ-015 disp_done received outside WAIT_DONE SHALL be ignored.
REQ-016 err_timeout SHALL be cleared by err_clr; a set and an err_clr in the same cycle SHALL leave it set.
REQ-017 Minimum latency SHALL be 3 cycles from accept (cycle N) to the first disp_wen (cycle N+3), given disp_rdy=1 and an empty queue.
REQ-018 A new message SHALL NOT start before the previous one has completed or timed out.

Reset
REQ-019 On rst, the FSM SHALL go to IDLE, the queue SHALL empty, the counters SHALL clear, and the outputs SHALL be: req_ready=1, disp_wen=0, disp_din=0, msg_done=0, err_timeout=0, busy=0.
REQ-020 Reset during SEND_HDR or SEND_DATA SHALL drop disp_wen the next cycle and discard the message.

Structure
REQ-021 The FSM state encoding and the DONE_TIMEOUT default SHALL live in a shared oled package.
REQ-022 The queue SHALL be the sub-module msg_req_fifo, width 42 bits = pos 8 + len 2 + value 32.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single message: pos=8'h23, len=1, value=32'h0000ABCD, disp_rdy=1 -> disp_wen high for 3 cycles, bytes 23,AB,CD; disp_done -> msg_done 1 cycle later.
- Back-pressure: queue 5 requests, DEPTH 4 -> req_ready=0 after the 4th; all 5 sent in order once drained.
- disp_rdy low: disp_rdy=0 for 10 cycles after the pop -> disp_wen stays 0, header issued in the cycle after disp_rdy rises.
- Timeout: DONE_TIMEOUT=16, never pulse disp_done -> err_timeout=1 after 16 WAIT_DONE cycles, next message proceeds; err_clr -> 0.
- Length 4: value=32'h12345678, len=3 -> data bytes 12,34,56,78 contiguous, header first.
- Mid-message reset: rst during the 2nd data byte -> disp_wen=0 the next cycle, busy=0, queue empty.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types for the OLED hex message feeder: FSM encoding, request layout,
// timeout default and the payload byte selector.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND_HDR,
    SEND_DATA,
    WAIT_DONE
  } state_t;

  localparam logic [23:0] DONE_TIMEOUT_DEF = 24'hFFFFFF;

  typedef struct packed {
    logic [7:0]  pos;
    logic [1:0]  len;
    logic [31:0] value;
  } msg_req_t;

  // Data byte k of a len+1 byte payload, most significant byte first.
  function automatic logic [7:0] data_byte(input logic [31:0] value,
                                           input logic [1:0]  len,
                                           input logic [1:0]  k);
    logic [1:0] sel;
    sel = len - k;
    return value[8*sel +: 8];
  endfunction

endpackage

// File: rtl/msg_req_fifo.sv
// Request queue: power-of-two depth, wrap-bit pointers, push accepted while full
// when a pop happens in the same cycle.
module msg_req_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/oled_hex_msg_feeder.sv
// Queues hex display requests and streams each as a header byte plus 1..4
// payload bytes to the display stage, then waits for its completion pulse.
module oled_hex_msg_feeder
  import oled_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [23:0] DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_pos,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_value,
  output logic        msg_done,
  output logic        err_timeout,
  input  logic        err_clr,
  output logic        busy,
  input  logic        disp_rdy,
  output logic        disp_wen,
  output logic [7:0]  disp_din,
  input  logic        disp_done
);
  state_t      state, state_nx;
  msg_req_t    req_in, q_out, msg;
  logic        q_empty, q_full, pop;
  logic [1:0]  byte_idx;
  logic [23:0] to_cnt;
  logic        timed_out;

  assign req_in    = '{pos: req_pos, len: req_len, value: req_value};
  assign req_ready = ~q_full;
  assign busy      = ~q_empty | (state != IDLE);
  // disp_done wins over a timeout landing in the same cycle
  assign timed_out = (state == WAIT_DONE) && !disp_done && (to_cnt == DONE_TIMEOUT - 24'd1);

  msg_req_fifo #(
    .WIDTH($bits(msg_req_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid & req_ready),
    .wdata (req_in),
    .pop   (pop),
    .rdata (q_out),
    .empty (q_empty),
    .full  (q_full)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:      if (!q_empty) begin
                   pop      = 1'b1;
                   state_nx = WAIT_RDY;
                 end
      WAIT_RDY:  if (disp_rdy) state_nx = SEND_HDR;
      SEND_HDR:  state_nx = SEND_DATA;
      SEND_DATA: if (byte_idx == msg.len) state_nx = WAIT_DONE;
      WAIT_DONE: if (disp_done || timed_out) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= '0;
      to_cnt      <= '0;
      msg_done    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nx;
      msg_done <= (state == WAIT_DONE) && disp_done;
      byte_idx <= (state == SEND_DATA) ? byte_idx + 1'b1 : 2'd0;
      // zero outside WAIT_DONE, so the count starts clean on every entry
      to_cnt   <= (state == WAIT_DONE) ? to_cnt + 24'd1 : 24'd0;
      if (timed_out)    err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) msg <= q_out;
  end

  always_comb begin
    disp_wen = 1'b0;
    disp_din = 8'h00;
    if (state == SEND_HDR) begin
      disp_wen = 1'b1;
      disp_din = msg.pos;
    end else if (state == SEND_DATA) begin
      disp_wen = 1'b1;
      disp_din = data_byte(msg.value, msg.len, byte_idx);
    end
  end

endmodule

// File: tb/tb_oled_hex_msg_feeder.sv
// Bench for oled_hex_msg_feeder: a monitor records every write burst and
// completion, and each scenario checks them against a byte-level message model.
module tb_oled_hex_msg_feeder;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, err_clr = 1'b0;
  logic        disp_rdy = 1'b1, disp_done = 1'b0;
  logic [7:0]  req_pos = '0;
  logic [1:0]  req_len = '0;
  logic [31:0] req_value = '0;
  logic        req_ready, msg_done, err_timeout, busy, disp_wen;
  logic [7:0]  disp_din;

  int vec = 0, errs = 0, cyc = 0;

  oled_hex_msg_feeder #(.FIFO_DEPTH(DEPTH), .DONE_TIMEOUT(24'(TMO))) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pos(req_pos), .req_len(req_len), .req_value(req_value),
    .msg_done(msg_done), .err_timeout(err_timeout), .err_clr(err_clr),
    .busy(busy), .disp_rdy(disp_rdy), .disp_wen(disp_wen),
    .disp_din(disp_din), .disp_done(disp_done)
  );

  always #5 clk = ~clk;

  // observed traffic and expected traffic
  logic [7:0] got[$];
  int         bstart[$], blens[$], ddone[$], mdone[$];
  logic [7:0] exp_b[$];
  int         exp_l[$];
  int         din_bad = 0, done_dly = 2, dcount = -1, blen = 0;
  bit         done_en = 1'b1;
  logic       wen_q = 1'b0;

  // Monitor and display responder: answers each burst with disp_done after done_dly cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    disp_done = 1'b0;
    if (!disp_wen && disp_din !== 8'h00) din_bad++;
    if (rst) begin
      wen_q = 1'b0; blen = 0; dcount = -1;
    end else begin
      if (disp_wen) begin
        if (!wen_q) bstart.push_back(cyc);
        got.push_back(disp_din);
        blen++;
      end else if (wen_q) begin
        blens.push_back(blen);
        blen = 0;
        if (done_en) dcount = done_dly;
      end
      if (dcount == 0) begin
        disp_done = 1'b1; ddone.push_back(cyc); dcount = -1;
      end else if (dcount > 0) dcount--;
      if (msg_done) mdone.push_back(cyc);
      wen_q = disp_wen;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_q();
    got.delete(); bstart.delete(); blens.delete(); ddone.delete(); mdone.delete();
    exp_b.delete(); exp_l.delete(); din_bad = 0;
  endtask

  // Expected wire image of one message: header, then payload MSB first.
  function automatic void model_msg(input logic [7:0] p, input logic [1:0] l, input logic [31:0] v);
    logic [31:0] t;
    exp_b.push_back(p);
    for (int k = 0; k <= int'(l); k++) begin
      t = v >> (8 * (int'(l) - k));
      exp_b.push_back(t[7:0]);
    end
    exp_l.push_back(int'(l) + 2);
  endfunction

  task automatic push_req(input logic [7:0] p, input logic [1:0] l, input logic [31:0] v,
                          output int acc);
    req_pos = p; req_len = l; req_value = v; req_valid = 1'b1;
    for (int i = 0; i < 300 && !req_ready; i++) step();
    acc = cyc;
    if (!req_ready) begin
      vec++; errs++;
      $display("FAIL push_wait: req_ready=%b after 300 cycles, need 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    model_msg(p, l, v);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && busy; i++) step();
    if (busy) begin
      vec++; errs++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, need 0", busy, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    vec++; if (req_ready !== 1'b1)   begin errs++; $display("FAIL rst_ready: got %b need 1", req_ready); end
    vec++; if (disp_wen !== 1'b0)    begin errs++; $display("FAIL rst_wen: got %b need 0", disp_wen); end
    vec++; if (disp_din !== 8'h00)   begin errs++; $display("FAIL rst_din: got %h need 00", disp_din); end
    vec++; if (msg_done !== 1'b0)    begin errs++; $display("FAIL rst_done: got %b need 0", msg_done); end
    vec++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL rst_err: got %b need 0", err_timeout); end
    vec++; if (busy !== 1'b0)        begin errs++; $display("FAIL rst_busy: got %b need 0", busy); end
    rst = 1'b0;
    step();
    clear_q();
  endtask

  task automatic test_single();
    int acc;
    logic [7:0] want[3];
    want = '{8'h23, 8'hAB, 8'hCD};
    clear_q(); done_en = 1'b1; done_dly = 2;
    push_req(8'h23, 2'd1, 32'h0000ABCD, acc);
    wait_idle(100);
    vec++; if (bstart.size() != 1 || bstart[0] != acc + 3)
      begin errs++; $display("FAIL single_latency: first wen cycle %0d, need %0d", bstart.size() ? bstart[0] : -1, acc + 3); end
    vec++; if (blens.size() != 1 || blens[0] != 3)
      begin errs++; $display("FAIL single_len: burst %0d, need 3", blens.size() ? blens[0] : -1); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (got.size() != 3 || got[i] !== want[i])
        begin errs++; $display("FAIL single_byte%0d: got %h need %h", i, got.size() > i ? got[i] : 8'hxx, want[i]); end
    end
    vec++; if (mdone.size() != 1 || ddone.size() != 1 || mdone[0] != ddone[0] + 1)
      begin errs++; $display("FAIL single_msg_done: %0d pulses, need 1 at disp_done+1", mdone.size()); end
    vec++; if (din_bad != 0) begin errs++; $display("FAIL single_din_idle: %0d nonzero bytes with wen=0, need 0", din_bad); end
  endtask

  task automatic test_disp_rdy_low();
    int acc, r;
    clear_q(); disp_rdy = 1'b0;
    push_req(8'h5A, 2'd0, 32'h0000_00E7, acc);
    step(10);
    vec++; if (bstart.size() != 0) begin errs++; $display("FAIL rdy_low_wen: %0d bursts while disp_rdy=0, need 0", bstart.size()); end
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL rdy_low_busy: got %b need 1", busy); end
    disp_rdy = 1'b1; r = cyc;
    wait_idle(100);
    vec++; if (bstart.size() != 1 || bstart[0] != r + 1)
      begin errs++; $display("FAIL rdy_low_hdr: header cycle %0d, need %0d", bstart.size() ? bstart[0] : -1, r + 1); end
    vec++; if (got.size() != 2 || got[0] !== 8'h5A || got[1] !== 8'hE7)
      begin errs++; $display("FAIL rdy_low_bytes: %0d bytes, need 5A E7", got.size()); end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_q(); disp_rdy = 1'b0; done_en = 1'b1; done_dly = 1;
    push_req(8'h01, 2'd0, 32'h11, acc);   // blocker held in the message registers
    step();
    for (int i = 0; i < 4; i++) begin
      push_req(8'($urandom), 2'($urandom), $urandom, acc);
      if (i == 2) begin
        vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL bp_ready3: got %b need 1", req_ready); end
      end
    end
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_full: got %b need 0", req_ready); end
    step(3);
    vec++; if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_hold: got %b need 0", req_ready); end
    disp_rdy = 1'b1;
    push_req(8'($urandom), 2'($urandom), $urandom, acc);
    wait_idle(400);
    vec++; if (blens.size() != exp_l.size()) begin errs++; $display("FAIL bp_count: %0d bursts, need %0d", blens.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < blens.size(); i++) begin
      vec++; if (blens[i] != exp_l[i]) begin errs++; $display("FAIL bp_len%0d: got %0d need %0d", i, blens[i], exp_l[i]); end
    end
    for (int i = 0; i < exp_b.size(); i++) begin
      vec++; if (i >= got.size() || got[i] !== exp_b[i])
        begin errs++; $display("FAIL bp_byte%0d: got %h need %h", i, i < got.size() ? got[i] : 8'hxx, exp_b[i]); end
    end
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL bp_drained: got %b need 1", req_ready); end
  endtask

  task automatic test_timeout();
    int acc, last, i;
    clear_q(); done_en = 1'b0;
    push_req(8'h77, 2'd2, 32'h00C0FFEE, acc);
    for (i = 0; i < 200 && !err_timeout; i++) step();
    last = (bstart.size() && blens.size()) ? bstart[0] + blens[0] - 1 : -1;
    vec++; if (err_timeout !== 1'b1 || cyc != last + TMO + 1)
      begin errs++; $display("FAIL tmo_set: err=%b at cycle %0d, need 1 at %0d", err_timeout, cyc, last + TMO + 1); end
    vec++; if (mdone.size() != 0 || busy !== 1'b0)
      begin errs++; $display("FAIL tmo_nodone: msg_done=%0d busy=%b, need 0 0", mdone.size(), busy); end
    // a disp_done one cycle past the window arrives in IDLE and must be ignored
    done_en = 1'b1; done_dly = TMO;
    push_req(8'h31, 2'd0, 32'h42, acc);
    wait_idle(100); step(3);
    vec++; if (mdone.size() != 0 || ddone.size() != 1)
      begin errs++; $display("FAIL tmo_late_done: msg_done=%0d, need 0", mdone.size()); end
    // disp_done on the last counted cycle is a success
    done_dly = TMO - 1;
    push_req(8'h32, 2'd3, 32'hA5A5_5A5A, acc);
    wait_idle(100);
    vec++; if (mdone.size() != 1) begin errs++; $display("FAIL tmo_edge_done: msg_done=%0d, need 1", mdone.size()); end
    vec++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL tmo_sticky: got %b need 1", err_timeout); end
    for (int k = 0; k < exp_b.size(); k++) begin
      vec++; if (k >= got.size() || got[k] !== exp_b[k])
        begin errs++; $display("FAIL tmo_byte%0d: got %h need %h", k, k < got.size() ? got[k] : 8'hxx, exp_b[k]); end
    end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    vec++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL tmo_clr: got %b need 0", err_timeout); end
    // set and clear in the same cycle leaves it set for one cycle
    done_en = 1'b0; err_clr = 1'b1;
    push_req(8'h33, 2'd0, 32'h1, acc);
    for (i = 0; i < 200 && !err_timeout; i++) step();
    vec++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL tmo_set_vs_clr: got %b need 1", err_timeout); end
    step();
    vec++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL tmo_clr_after: got %b need 0", err_timeout); end
    err_clr = 1'b0; done_en = 1'b1;
  endtask

  task automatic test_len4();
    int acc;
    logic [7:0] want[5];
    want = '{8'hC4, 8'h12, 8'h34, 8'h56, 8'h78};
    clear_q(); done_dly = 0;
    push_req(8'hC4, 2'd3, 32'h12345678, acc);
    wait_idle(100);
    vec++; if (blens.size() != 1 || blens[0] != 5)
      begin errs++; $display("FAIL len4_burst: got %0d need 5", blens.size() ? blens[0] : -1); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (got.size() != 5 || got[i] !== want[i])
        begin errs++; $display("FAIL len4_byte%0d: got %h need %h", i, got.size() > i ? got[i] : 8'hxx, want[i]); end
    end
  endtask

  task automatic test_random();
    int acc;
    clear_q();
    for (int n = 0; n < 10; n++) begin
      done_dly = $urandom_range(0, 10);
      push_req(8'($urandom), 2'($urandom), $urandom, acc);
      step($urandom_range(0, 3));
    end
    wait_idle(1000);
    vec++; if (mdone.size() != 10 || err_timeout !== 1'b0)
      begin errs++; $display("FAIL rnd_done: %0d msg_done err=%b, need 10 0", mdone.size(), err_timeout); end
    vec++; if (got.size() != exp_b.size()) begin errs++; $display("FAIL rnd_count: %0d bytes, need %0d", got.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
      vec++; if (got[i] !== exp_b[i]) begin errs++; $display("FAIL rnd_byte%0d: got %h need %h", i, got[i], exp_b[i]); end
    end
    for (int i = 0; i < exp_l.size() && i < blens.size(); i++) begin
      vec++; if (blens[i] != exp_l[i]) begin errs++; $display("FAIL rnd_len%0d: got %0d need %0d", i, blens[i], exp_l[i]); end
    end
    vec++; if (din_bad != 0) begin errs++; $display("FAIL rnd_din_idle: %0d nonzero bytes with wen=0, need 0", din_bad); end
  endtask

  task automatic test_mid_reset();
    int acc, s, i;
    clear_q(); done_en = 1'b1; done_dly = 1;
    push_req(8'h9E, 2'd3, 32'hDEADBEEF, acc);
    push_req(8'h9F, 2'd1, 32'h0000_1234, acc);
    push_req(8'hA0, 2'd0, 32'h0000_0056, acc);
    for (i = 0; i < 50 && bstart.size() == 0; i++) step();
    s = bstart.size() ? bstart[0] : cyc;
    while (cyc < s + 2) step();
    vec++; if (disp_wen !== 1'b1 || disp_din !== 8'hAD)
      begin errs++; $display("FAIL mid_pre: wen=%b din=%h, need 1 AD", disp_wen, disp_din); end
    rst = 1'b1; step();
    vec++; if (disp_wen !== 1'b0) begin errs++; $display("FAIL mid_wen: got %b need 0", disp_wen); end
    vec++; if (busy !== 1'b0 || req_ready !== 1'b1)
      begin errs++; $display("FAIL mid_state: busy=%b ready=%b, need 0 1", busy, req_ready); end
    rst = 1'b0; clear_q();
    step(6);
    vec++; if (bstart.size() != 0 || busy !== 1'b0)
      begin errs++; $display("FAIL mid_flushed: %0d bursts busy=%b, need 0 0", bstart.size(), busy); end
  endtask

  initial begin
    step();
    test_reset();
    test_single();
    test_disp_rdy_low();
    test_back_to_back();
    test_timeout();
    test_len4();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
